f8_reset_controller: RTL
========================

// Module: f8_reset_controller
// PURPOSE
//   Reset/trap/watchdog sequencer that drives the active-high reset of the f8
//   system. Stretches power-on reset, turns a CPU trap or a watchdog timeout
//   into a clean, timed system restart, and halts the system after repeated
//   traps. Sits between the board-level power-on reset and the system.
// PARAMETERS
//   STRETCH_CYCLES  8   clk edges sys_reset stays high per hold (>=1)
//   WDT_WIDTH       16  watchdog counter / reload width
//   TRAP_RESTART    1   1: trap restarts system; 0: any trap halts
//   MAX_TRAPS       3   trap count that forces HALT (1..15)
// PORTS
//   clk              in   1          system clock
//   power_on_reset_n in   1          async active-low reset
//   trap             in   1          trap from system, edge-detected
//   wdt_enable       in   1          watchdog counts while high
//   wdt_kick         in   1          reloads watchdog (1-cycle pulse)
//   wdt_reload       in   WDT_WIDTH  watchdog reload value
//   sys_reset        out  1          active-high reset to system
//   halted           out  1          1 = locked out after traps
//   reset_cause      out  2          00 POR, 01 trap, 10 watchdog
//   trap_count       out  4          traps since last POR, saturating
// BEHAVIOUR
// - Reset values while power_on_reset_n=0:
//   - state=HOLD, hold count=0, sys_reset=1, halted=0.
//   - reset_cause=00, trap_count=0, trap_q=0, wdt count=0.
// - All outputs are registered.
// - Deassertion of power_on_reset_n is synchronised through 2 flops. HOLD
//   counting starts on the first edge after the synchronised release.
// - States:
//   - HOLD: sys_reset=1. Count increments each edge. At count ==
//     STRETCH_CYCLES-1 -> RUN, count cleared, wdt count <= wdt_reload.
//     sys_reset is therefore high for exactly STRETCH_CYCLES edges after
//     release.
//   - RUN: sys_reset=0. Trap event = trap & ~trap_q (trap_q samples trap
//     every edge, in all states).
//     - Trap event: trap_count += 1 (saturates at 15).
//     - If TRAP_RESTART=0, or the new trap_count >= MAX_TRAPS -> HALT.
//     - Otherwise -> HOLD with reset_cause=01.
//     - Watchdog, only when wdt_enable=1:
//       - wdt_kick reloads the count.
//       - Else if count==0: expiry -> HOLD with reset_cause=10.
//       - Else count decrements.
//     - With wdt_enable=0 the count holds its value.
//   - HALT: sys_reset=1, halted=1. Only power_on_reset_n leaves HALT.
// - Priority in the same RUN cycle:
//   - trap event > watchdog expiry.
//   - wdt_kick beats expiry, so no reset.
// - Trap events and wdt_kick are ignored in HOLD and HALT.
// - wdt_reload=0 with enable=1: expiry on the first RUN edge unless kicked.
// - trap_count and reset_cause clear only on power_on_reset_n. They survive
//   trap/WDT restarts.
// - Async reset mid-HOLD or mid-HALT: immediate return to reset values; the
//   stretch restarts.
// - Latency: trap/expiry seen on edge N -> sys_reset=1 after edge N.
// TESTING
//   1. power_on_reset_n low 5 cycles, then high -> sys_reset high for
//      2 sync + 8 edges, then 0; reset_cause=00, trap_count=0.
//   2. RUN, 1-cycle trap pulse -> sys_reset=1 next edge, reset_cause=01,
//      trap_count=1; 8 edges later sys_reset=0.
//   3. MAX_TRAPS=3, third trap -> halted=1, sys_reset stays 1 for 100+ cycles;
//      power_on_reset_n pulse -> halted=0, trap_count=0.
//   4. wdt_enable=1, reload=20, no kick -> sys_reset rises on the 21st edge
//      after RUN entry, cause=10; kick every 10 cycles -> no reset in 500.
//   5. Trap edge and expiry in the same cycle -> cause=01. Kick and count==0
//      in the same cycle -> no reset, count=reload.
//   6. power_on_reset_n asserted 3 cycles into a trap HOLD -> sys_reset=1,
//      cause=00, trap_count=0 at once; a full 8-edge stretch follows release.

Source files
------------

// File: rtl/f8_reset_controller.sv
// Reset/trap/watchdog sequencer for the f8 system: stretches power-on reset,
// turns traps and watchdog expiry into timed restarts, and locks out after repeated traps.
module f8_reset_controller #(
    parameter int STRETCH_CYCLES = 8,
    parameter int WDT_WIDTH      = 16,
    parameter int TRAP_RESTART   = 1,
    parameter int MAX_TRAPS      = 3
) (
    input  logic                 clk,
    input  logic                 power_on_reset_n,
    input  logic                 trap,
    input  logic                 wdt_enable,
    input  logic                 wdt_kick,
    input  logic [WDT_WIDTH-1:0] wdt_reload,
    output logic                 sys_reset,
    output logic                 halted,
    output logic [1:0]           reset_cause,
    output logic [3:0]           trap_count
);

    typedef enum logic [1:0] {HOLD = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;

    localparam int            CW        = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(STRETCH_CYCLES - 1);
    localparam logic [3:0]    MAX_TC    = 4'(MAX_TRAPS);

    logic [1:0]           sync_q;
    logic                 released;
    state_e               state_q, state_d;
    logic [CW-1:0]        hold_q, hold_d;
    logic [WDT_WIDTH-1:0] wdt_q, wdt_d;
    logic                 trap_q;
    logic [3:0]           tc_q, tc_d, tc_inc;
    logic [1:0]           cause_q, cause_d;
    logic                 sys_reset_q, sys_reset_d;
    logic                 halted_q, halted_d;
    logic                 trap_evt;

    // Release is synchronised; assertion stays asynchronous.
    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) sync_q <= 2'b00;
        else                   sync_q <= {sync_q[0], 1'b1};
    end
    assign released = sync_q[1];

    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            state_q     <= HOLD;
            hold_q      <= '0;
            wdt_q       <= '0;
            trap_q      <= 1'b0;
            tc_q        <= 4'd0;
            cause_q     <= 2'b00;
            sys_reset_q <= 1'b1;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            wdt_q       <= wdt_d;
            trap_q      <= trap;
            tc_q        <= tc_d;
            cause_q     <= cause_d;
            sys_reset_q <= sys_reset_d;
            halted_q    <= halted_d;
        end
    end

    assign trap_evt = trap & ~trap_q;
    assign tc_inc   = (tc_q == 4'hF) ? tc_q : tc_q + 4'd1;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        wdt_d   = wdt_q;
        tc_d    = tc_q;
        cause_d = cause_q;
        case (state_q)
            HOLD: begin
                if (released) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = RUN;
                        hold_d  = '0;
                        wdt_d   = wdt_reload;
                    end else begin
                        hold_d = hold_q + CW'(1);
                    end
                end
            end
            RUN: begin
                // A trap edge outranks anything the watchdog does this cycle.
                if (trap_evt) begin
                    tc_d = tc_inc;
                    if (TRAP_RESTART == 0 || tc_inc >= MAX_TC) begin
                        state_d = HALT;
                    end else begin
                        state_d = HOLD;
                        cause_d = 2'b01;
                    end
                end else if (wdt_enable) begin
                    if (wdt_kick) begin
                        wdt_d = wdt_reload;
                    end else if (wdt_q == '0) begin
                        state_d = HOLD;
                        cause_d = 2'b10;
                    end else begin
                        wdt_d = wdt_q - WDT_WIDTH'(1);
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = HOLD;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge.
    always_comb begin
        sys_reset_d = (state_d != RUN);
        halted_d    = (state_d == HALT);
    end

    assign sys_reset   = sys_reset_q;
    assign halted      = halted_q;
    assign reset_cause = cause_q;
    assign trap_count  = tc_q;

endmodule
